keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
- 4x4 matrix keypad front end: drives columns, synchronises and samples rows, debounces, encodes key, buffers codes in a small FIFO.
- Sits directly upstream of the keypad AXI4-Lite slave register block. That block reads `key_code`/`key_avail`/`fifo_count`/`overflow` and issues `key_pop`/`ovf_clr`.

Parameters:
- SCAN_DIV, 100000, clk cycles per scan tick (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_TICKS, 20, consecutive agreeing ticks required for press and for release; >= 1.
- FIFO_DEPTH, 4, key code FIFO entries; power of 2.
- REPEAT_DELAY, 500, ticks held before first auto-repeat (used only with the optional feature).
- REPEAT_RATE, 100, ticks between auto-repeats (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_p  in  1  synchronous, active-high reset
- row  in  4  keypad rows, active-low (pulled up externally), asynchronous
- col  out  4  column drive, one-hot-low
- key_code  out  4  FIFO head code = row_idx*4 + col_idx; 0 when empty
- key_avail  out  1  FIFO not empty
- key_pop  in  1  pop head (single-cycle pulse)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
- key_down  out  1  debounced key held (level)
- overflow  out  1  sticky: a code was dropped because the FIFO was full
- ovf_clr  in  1  clears overflow

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset_p).
- Reset values:
  - col=4'b1110 (col_idx 0); state SCAN.
  - Tick, debounce and repeat counters 0.
  - FIFO empty; key_code=0, key_avail=0, fifo_count=0, key_down=0, overflow=0.
- Reset mid-operation returns everything to reset values on the next edge; FIFO contents are discarded.
- Row input: 2-flop synchroniser; all decisions use the synced value.
- Tick: free-running counter 0..SCAN_DIV-1; tick is a 1-cycle pulse when the count equals SCAN_DIV-1.
- col is held constant for a whole tick period and only changes on a tick edge.
- FSM state SCAN:
  - On tick, sample synced row.
  - If any bit is low: latch col_idx and row_idx (lowest low row index wins), set deb_cnt=1, go to DEBOUNCE. If DEBOUNCE_TICKS=1, push and go straight to HELD.
  - Otherwise advance col_idx (3 wraps to 0).
- FSM state DEBOUNCE:
  - col is frozen.
  - On tick with the latched row still low: deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, push the code and go to HELD.
  - On tick with the latched row high: go to SCAN and advance col.
- FSM state HELD:
  - key_down=1; col is frozen.
  - On tick with the row high: rel_cnt++. At DEBOUNCE_TICKS go to SCAN, advance col, key_down=0.
  - On tick with the row low: rel_cnt=0.
- Other rows changing while in DEBOUNCE or HELD are ignored.
- key_down is registered; it rises in the same cycle the push is written.
- Exactly one push per debounced press (without the optional feature).
- FIFO push/pop rules:
  - Push when not full: write, count+1.
  - Push when full with no pop: code dropped, overflow set.
  - Push and pop together when full: both accepted, count unchanged, no overflow.
  - Pop when empty: ignored.
  - key_code/key_avail/fifo_count update one cycle after push/pop.
- Overflow register: ovf_clr and a new overflow in the same cycle → set wins.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, rep_cnt starts at 0 on entry and increments on each tick with the row low.
  - Push the same code when rep_cnt==REPEAT_DELAY, then each further REPEAT_RATE ticks.
  - A high tick freezes rep_cnt; rep_cnt resets on leaving HELD.
  - Repeat pushes follow the same full/overflow rules as normal pushes.
- Undefined: no repeat logic; REPEAT_* parameters unused.

Test Plan (SCAN_DIV=4, DEBOUNCE_TICKS=3, FIFO_DEPTH=4, REPEAT_DELAY=5, REPEAT_RATE=2):
- reset_p high 3 cycles mid-scan with 2 codes queued → col=4'b1110, fifo_count=0, key_avail=0, key_down=0, overflow=0.
- Hold row[2] low while col_idx=1 for 12 ticks, then release → exactly one push, key_code=4'h9, key_down high until 3 high ticks after release, then scanning resumes at col_idx 2.
- Row[0] low for 2 ticks then high (bounce) → no push, fifo_count=0, col advances.
- Five presses (codes 0,5,A,F,3) with no pops → fifo_count=4, overflow=1, key_code=0; ovf_clr → overflow=0; four key_pop pulses yield 0,5,A,F, then key_avail=0.
- FIFO full, key_pop asserted in the same cycle as a push of code 3 → fifo_count stays 4, overflow stays 0, last entry is 3.
- With KEYPAD_AUTOREPEAT_EN: hold one key for 10 ticks past entering HELD → 1 + 3 pushes (rep_cnt 5, 7, 9); without the macro → 1 push.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, 2-flop row sync, press/release debounce, key code FIFO; optional auto-repeat under KEYPAD_AUTOREPEAT_EN.
// Latency: code visible one cycle after the debounced push; backpressure: a full FIFO drops new codes and sets sticky overflow.

module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic                     in_vld,
  input  logic [W-1:0]             in_dat,
  output logic                     in_rdy,
  output logic                     out_vld,
  output logic [W-1:0]             out_dat,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          wr_en;
  logic          rd_en;

  assign full    = (cnt_q == CW'(DEPTH));
  assign out_vld = (cnt_q != '0);
  assign rd_en   = out_vld && out_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign in_rdy  = !full || out_rdy;
  assign wr_en   = in_vld && in_rdy;
  assign out_dat = mem[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= in_dat;
  end
endmodule

module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int FIFO_DEPTH     = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic                          clk,
  input  logic                          reset_p,
  input  logic [3:0]                    row,
  output logic [3:0]                    col,
  output logic [3:0]                    key_code,
  output logic                          key_avail,
  input  logic                          key_pop,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          key_down,
  output logic                          overflow,
  input  logic                          ovf_clr
);
  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_TICKS < 1 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_cfg
    $error("keypad_scan_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [3:0]    row_s1_q, row_s2_q;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [1:0]    low_idx;
  logic          row_any_low;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [DW-1:0] rel_cnt_q, rel_cnt_d;
  logic          key_down_q, key_down_d;
  logic          push;
  logic [3:0]    push_code;
  logic          fifo_in_rdy;
  logic [3:0]    head_dat;
  logic          ovf_set;
  logic          overflow_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW  = $clog2(REPEAT_DELAY + 1);
  localparam int RRW = $clog2(REPEAT_RATE + 1);
  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic [RRW-1:0] rate_cnt_q, rate_cnt_d;
`endif

  assign tick = (tick_cnt_q == TW'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset_p || tick) tick_cnt_q <= '0;
    else                 tick_cnt_q <= tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
    end
  end

  assign row_any_low = ~&row_s2_q;

  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s2_q[i]) low_idx = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= SCAN;
      col_idx_q  <= 2'd0;
      row_idx_q  <= 2'd0;
      deb_cnt_q  <= '0;
      rel_cnt_q  <= '0;
      key_down_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q  <= '0;
      rate_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      deb_cnt_q  <= deb_cnt_d;
      rel_cnt_q  <= rel_cnt_d;
      key_down_q <= key_down_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
      rate_cnt_q <= rate_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    deb_cnt_d  = deb_cnt_q;
    rel_cnt_d  = rel_cnt_q;
    key_down_d = key_down_q;
    push       = 1'b0;
    push_code  = {row_idx_q, col_idx_q};
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
    rate_cnt_d = rate_cnt_q;
    // Repeat timing only lives in HELD; anywhere else it restarts from zero.
    if (state_q != HELD) begin
      rep_cnt_d  = '0;
      rate_cnt_d = '0;
    end
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (row_any_low) begin
            row_idx_d = low_idx;
            deb_cnt_d = DW'(1);
            rel_cnt_d = '0;
            if (DEBOUNCE_TICKS == 1) begin
              push       = 1'b1;
              push_code  = {low_idx, col_idx_q};
              key_down_d = 1'b1;
              state_d    = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!row_s2_q[row_idx_q]) begin
            deb_cnt_d = deb_cnt_q + DW'(1);
            if (deb_cnt_d == DW'(DEBOUNCE_TICKS)) begin
              push       = 1'b1;
              key_down_d = 1'b1;
              rel_cnt_d  = '0;
              state_d    = HELD;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
            state_d   = SCAN;
          end
        end
        HELD: begin
          if (row_s2_q[row_idx_q]) begin
            rel_cnt_d = rel_cnt_q + DW'(1);
            if (rel_cnt_d == DW'(DEBOUNCE_TICKS)) begin
              rel_cnt_d  = '0;
              key_down_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = SCAN;
            end
          end else begin
            rel_cnt_d = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            // rep_cnt saturates at the delay; rate_cnt then spaces later repeats.
            if (rep_cnt_q != RW'(REPEAT_DELAY)) begin
              rep_cnt_d = rep_cnt_q + RW'(1);
              if (rep_cnt_d == RW'(REPEAT_DELAY)) push = 1'b1;
            end else if (rate_cnt_q == RRW'(REPEAT_RATE - 1)) begin
              push       = 1'b1;
              rate_cnt_d = '0;
            end else begin
              rate_cnt_d = rate_cnt_q + RRW'(1);
            end
`endif
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  sync_fifo #(
    .W     (4),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_p (reset_p),
    .in_vld  (push),
    .in_dat  (push_code),
    .in_rdy  (fifo_in_rdy),
    .out_vld (key_avail),
    .out_dat (head_dat),
    .out_rdy (key_pop),
    .count   (fifo_count)
  );

  assign ovf_set = push && !fifo_in_rdy;

  always_ff @(posedge clk) begin
    if (reset_p)      overflow_q <= 1'b0;
    else if (ovf_set) overflow_q <= 1'b1;
    else if (ovf_clr) overflow_q <= 1'b0;
  end

  assign col      = ~(4'b0001 << col_idx_q);
  assign key_code = key_avail ? head_dat : 4'h0;
  assign key_down = key_down_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad model answers the column drive; expected codes are queued at each
// debounced press (and modelled repeat) and compared as they are popped from the DUT FIFO.
module tb_keypad_scan_ctrl;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int DEPTH    = 4;
  localparam int RDELAY   = 5;
  localparam int RRATE    = 2;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_avail;
  logic       key_pop;
  logic [2:0] fifo_count;
  logic       key_down;
  logic       overflow;
  logic       ovf_clr;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_TICKS (DEB),
    .FIFO_DEPTH     (DEPTH),
    .REPEAT_DELAY   (RDELAY),
    .REPEAT_RATE    (RRATE)
  ) dut (
    .clk        (clk),
    .reset_p    (reset_p),
    .row        (row),
    .col        (col),
    .key_code   (key_code),
    .key_avail  (key_avail),
    .key_pop    (key_pop),
    .fifo_count (fifo_count),
    .key_down   (key_down),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  // Keypad: a closed switch pulls its row low while its column is driven low.
  logic       key_on;
  logic [1:0] key_r, key_c;
  logic [3:0] force_low;

  always_comb begin
    row = 4'hF;
    if (key_on && !col[key_c]) row[key_r] = 1'b0;
    row = row & ~force_low;
  end

  // Reference scan-tick phase: the DUT ticks on the edge after tb_cnt reads SCAN_DIV-1.
  int tb_cnt = 0;
  always @(posedge clk) begin
    if (reset_p || tb_cnt == SCAN_DIV - 1) tb_cnt <= 0;
    else                                   tb_cnt <= tb_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [3:0] q[$];
  bit exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] code);
    if (q.size() < DEPTH) q.push_back(code);
    else                  exp_ovf = 1'b1;
  endtask

  // Returns at the negedge just after the next scan-tick edge.
  task automatic next_tick();
    @(negedge clk);
    while (tb_cnt != SCAN_DIV - 1) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold,
                       input bit pop_at_push, input bit chk_rel);
    int n;
    bit found;
    logic [3:0] want;
    logic [3:0] code;
    code  = {r, c};
    want  = ~(4'b0001 << c);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      next_tick();
      if (col == want) found = 1'b1;
    end
    chk("align", found, 1);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
    next_tick();
    next_tick();
    chk("kd_pre", key_down, 0);
    @(negedge clk);
    while (tb_cnt != SCAN_DIV - 1) @(negedge clk);
    if (pop_at_push) begin
      chk("pp_head", key_code, q[0]);
      key_pop = 1'b1;
    end
    @(negedge clk);
    key_pop = 1'b0;
    if (pop_at_push) void'(q.pop_front());
    chk("kd_rise", key_down, 1);
    model_push(code);
    for (int t = 1; t <= hold; t++) begin
      next_tick();
`ifdef KEYPAD_AUTOREPEAT_EN
      if (t == RDELAY || (t > RDELAY && (t - RDELAY) % RRATE == 0)) model_push(code);
`endif
    end
    key_on = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_down === 1'b1 && n < 40);
    if (chk_rel) chk("rel_lat", n, 12);
    chk("kd_fall", key_down, 0);
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) begin
      chk("avail", key_avail, 1);
      chk(tag, key_code, q[0]);
      key_pop = 1'b1;
      @(negedge clk);
      key_pop = 1'b0;
      void'(q.pop_front());
    end
    chk("empty_avail", key_avail, 0);
    chk("empty_cnt", fifo_count, 0);
    chk("empty_code", key_code, 0);
  endtask

  task automatic reset_checks();
    chk("rst_col", col, 4'b1110);
    chk("rst_cnt", fifo_count, 0);
    chk("rst_avail", key_avail, 0);
    chk("rst_code", key_code, 0);
    chk("rst_kd", key_down, 0);
    chk("rst_ovf", overflow, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] c0;
    reset_p   = 1'b1;
    key_pop   = 1'b0;
    ovf_clr   = 1'b0;
    key_on    = 1'b0;
    key_r     = 2'd0;
    key_c     = 2'd0;
    force_low = 4'h0;
    repeat (3) @(negedge clk);
    reset_checks();
    reset_p = 1'b0;

    // Single long press at row 2 / col 1, release, scanning resumes at col 2.
    press(2'd2, 2'd1, 12, 1'b0, 1'b1);
    chk("b_col_resume", col, 4'b1011);
    chk("b_cnt", fifo_count, q.size());
    chk("b_ovf", overflow, exp_ovf);
    drain("b_pop");
    key_pop = 1'b1;
    @(negedge clk);
    key_pop = 1'b0;
    chk("pop_empty_cnt", fifo_count, 0);

    // Two-tick bounce on row 0: no push, column moves on.
    next_tick();
    force_low = 4'b0001;
    next_tick();
    c0 = col;
    next_tick();
    chk("bnc_frozen", col, c0);
    force_low = 4'b0000;
    next_tick();
    chk("bnc_adv", col, {c0[2:0], c0[3]});
    chk("bnc_cnt", fifo_count, 0);
    chk("bnc_kd", key_down, 0);

    // Five presses into a four-entry FIFO.
    press(2'd0, 2'd0, 1, 1'b0, 1'b0);
    press(2'd1, 2'd1, 1, 1'b0, 1'b0);
    press(2'd2, 2'd2, 1, 1'b0, 1'b0);
    press(2'd3, 2'd3, 1, 1'b0, 1'b0);
    press(2'd0, 2'd3, 1, 1'b0, 1'b0);
    chk("d_cnt", fifo_count, q.size());
    chk("d_ovf", overflow, exp_ovf);
    chk("d_head", key_code, q[0]);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("d_ovf_clr", overflow, 0);
    drain("d_pop");

    // Full FIFO: pop coincides with the push of code 3.
    press(2'd0, 2'd1, 1, 1'b0, 1'b0);
    press(2'd0, 2'd2, 1, 1'b0, 1'b0);
    press(2'd1, 2'd0, 1, 1'b0, 1'b0);
    press(2'd2, 2'd0, 1, 1'b0, 1'b0);
    press(2'd0, 2'd3, 1, 1'b1, 1'b0);
    chk("e_cnt", fifo_count, 4);
    chk("e_ovf", overflow, 0);
    drain("e_pop");

    // Reset in mid-scan with two codes queued.
    press(2'd1, 2'd2, 1, 1'b0, 1'b0);
    press(2'd3, 2'd0, 1, 1'b0, 1'b0);
    chk("f_cnt", fifo_count, 2);
    repeat (3) @(negedge clk);
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks();
    reset_p = 1'b0;
    q.delete();
    exp_ovf = 1'b0;

    // Hold for ten ticks after the press is accepted.
    press(2'd3, 2'd1, 10, 1'b0, 1'b0);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("g_rep_cnt", fifo_count, 4);
`else
    chk("g_rep_cnt", fifo_count, 1);
`endif
    chk("g_ovf", overflow, exp_ovf);
    drain("g_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
